// File: rtl/cog_vid_gen.sv
// Per-cog video shifter: serialises WAITVID colour/pixel longs into an 8-bit
// colour stream on one pin group, paced by rising edges of the counter pll.
module cog_vid_gen #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk_cog,
    input  logic        nres,
    input  logic        ena,
    input  logic        setvcfg,
    input  logic        setvscl,
    input  logic [31:0] data,
    input  logic        pll,
    input  logic        svid,
    input  logic [31:0] sc,
    input  logic [31:0] sp,
    output logic        vack,
    output logic [31:0] pin_out,
    output logic        busy
);

    typedef enum logic {StOff, StRun} state_t;

    state_t                 state;
    logic                   vcfg_en;
    logic                   vcfg_mode;
    logic [1:0]             vcfg_grp;
    logic [7:0]             vcfg_mask;
    logic [19:0]            vscl;
    logic [SYNC_STAGES-1:0] pll_sync;
    logic                   pll_prev;
    logic                   tick;
    logic [31:0]            hold_sc;
    logic [31:0]            hold_sp;
    logic [31:0]            act_sc;
    logic [31:0]            act_sp;
    logic [31:0]            shift_sp;
    logic [8:0]             pcnt;
    logic [12:0]            fcnt;
    logic [8:0]             pix_reload;
    logic [12:0]            frm_reload;
    logic [1:0]             idx;
    logic [7:0]             colour;
    logic [31:0]            pin_next;
    logic                   unused_data;

    assign unused_data = ^{data[31:30], data[27:26], data[23:20]};

    assign pix_reload = (vscl[19:12] == 8'd0) ? 9'd256 : {1'b0, vscl[19:12]};
    assign frm_reload = (vscl[11:0] == 12'd0) ? 13'd4096 : {1'b0, vscl[11:0]};

    always_ff @(posedge clk_cog or negedge nres) begin
        if (!nres) begin
            pll_sync <= '0;
            pll_prev <= 1'b0;
            tick     <= 1'b0;
        end else begin
            pll_sync <= {pll_sync[SYNC_STAGES-2:0], pll};
            pll_prev <= pll_sync[SYNC_STAGES-1];
            tick     <= pll_sync[SYNC_STAGES-1] & ~pll_prev;
        end
    end

    always_comb begin
        idx = vcfg_mode ? shift_sp[1:0] : {1'b0, shift_sp[0]};
        case (idx)
            2'd0:    colour = act_sc[7:0];
            2'd1:    colour = act_sc[15:8];
            2'd2:    colour = act_sc[23:16];
            default: colour = act_sc[31:24];
        endcase
        pin_next = {24'd0, colour & vcfg_mask} << {vcfg_grp, 3'b000};
    end

    always_ff @(posedge clk_cog or negedge nres) begin
        if (!nres) begin
            state     <= StOff;
            vcfg_en   <= 1'b0;
            vcfg_mode <= 1'b0;
            vcfg_grp  <= 2'd0;
            vcfg_mask <= 8'd0;
            vscl      <= 20'd0;
            hold_sc   <= 32'd0;
            hold_sp   <= 32'd0;
            act_sc    <= 32'd0;
            act_sp    <= 32'd0;
            shift_sp  <= 32'd0;
            pcnt      <= 9'd0;
            fcnt      <= 13'd0;
            vack      <= 1'b0;
            busy      <= 1'b0;
            pin_out   <= 32'd0;
        end else begin
            vack <= 1'b0;
            if (!ena) begin
                vcfg_en   <= 1'b0;
                vcfg_mode <= 1'b0;
                vcfg_grp  <= 2'd0;
                vcfg_mask <= 8'd0;
            end else if (setvcfg) begin
                vcfg_en   <= data[29];
                vcfg_mode <= data[28];
                vcfg_grp  <= data[25:24];
                vcfg_mask <= data[7:0];
            end
            if (setvscl) begin
                vscl <= data[19:0];
            end
            if (svid && !busy && !vack) begin
                hold_sc <= sc;
                hold_sp <= sp;
                busy    <= 1'b1;
            end

            case (state)
                StOff: begin
                    pcnt     <= pix_reload;
                    fcnt     <= frm_reload;
                    act_sc   <= 32'd0;
                    act_sp   <= 32'd0;
                    shift_sp <= 32'd0;
                    if (!vcfg_en) begin
                        // Disabled: release the cog straight away.
                        if (busy) begin
                            vack <= 1'b1;
                            busy <= 1'b0;
                        end
                    end else if (tick) begin
                        state <= StRun;
                        if (busy) begin
                            act_sc   <= hold_sc;
                            act_sp   <= hold_sp;
                            shift_sp <= hold_sp;
                            vack     <= 1'b1;
                            busy     <= 1'b0;
                        end
                    end
                end
                StRun: begin
                    if (!vcfg_en) begin
                        state    <= StOff;
                        pcnt     <= pix_reload;
                        fcnt     <= frm_reload;
                        act_sc   <= 32'd0;
                        act_sp   <= 32'd0;
                        shift_sp <= 32'd0;
                    end else if (tick) begin
                        if (fcnt == 13'd1) begin
                            pcnt <= pix_reload;
                            fcnt <= frm_reload;
                            if (busy) begin
                                act_sc   <= hold_sc;
                                act_sp   <= hold_sp;
                                shift_sp <= hold_sp;
                                vack     <= 1'b1;
                                busy     <= 1'b0;
                            end else begin
                                // Starved: replay the last frame's pixels.
                                shift_sp <= act_sp;
                            end
                        end else begin
                            fcnt <= fcnt - 13'd1;
                            if (pcnt == 9'd1) begin
                                pcnt     <= pix_reload;
                                shift_sp <= vcfg_mode ? {2'b00, shift_sp[31:2]}
                                                      : {1'b0, shift_sp[31:1]};
                            end else begin
                                pcnt <= pcnt - 9'd1;
                            end
                        end
                    end
                end
                default: state <= StOff;
            endcase

            pin_out <= (state == StRun && ena && vcfg_en) ? pin_next : 32'd0;
        end
    end

endmodule

// File: tb/tb_cog_vid_gen.sv
// Self-checking bench for cog_vid_gen: pll pulses drive ticks, a reference model
// fills a scoreboard of expected pin_out values, handshakes are checked inline.
module tb_cog_vid_gen;

    logic        clk_cog = 1'b0;
    logic        nres    = 1'b0;
    logic        ena     = 1'b0;
    logic        setvcfg = 1'b0;
    logic        setvscl = 1'b0;
    logic [31:0] data    = 32'd0;
    logic        pll     = 1'b0;
    logic        svid    = 1'b0;
    logic [31:0] sc      = 32'd0;
    logic [31:0] sp      = 32'd0;
    logic        vack;
    logic [31:0] pin_out;
    logic        busy;

    int checks   = 0;
    int errors   = 0;
    int vack_cnt = 0;
    int kidx     = 0;

    logic [31:0] m_sc   = 32'd0;
    logic [31:0] m_sp   = 32'd0;
    logic [7:0]  m_mask = 8'd0;
    logic        m_mode = 1'b0;
    int unsigned m_g    = 0;
    int unsigned m_p    = 1;
    int unsigned m_f    = 1;

    logic [31:0] exp_q[$];

    always #5 clk_cog = ~clk_cog;

    cog_vid_gen #(.SYNC_STAGES(2)) dut (
        .clk_cog (clk_cog),
        .nres    (nres),
        .ena     (ena),
        .setvcfg (setvcfg),
        .setvscl (setvscl),
        .data    (data),
        .pll     (pll),
        .svid    (svid),
        .sc      (sc),
        .sp      (sp),
        .vack    (vack),
        .pin_out (pin_out),
        .busy    (busy)
    );

    // Expected pin_out for the k-th tick since the first frame load.
    function automatic logic [31:0] model(input int unsigned k);
        int unsigned pos;
        int unsigned pix;
        int unsigned sel;
        logic [7:0]  col;
        pos = k % m_f;
        pix = pos / m_p;
        sel = 0;
        if (!m_mode) begin
            if (pix < 32 && m_sp[pix]) sel = 1;
        end else if (pix < 16) begin
            sel = (m_sp[2*pix+1] ? 2 : 0) + (m_sp[2*pix] ? 1 : 0);
        end
        col = m_sc[8*sel +: 8];
        return {24'd0, col & m_mask} << (8 * m_g);
    endfunction

    // One clock step; the cog drops svid as soon as it sees vack.
    task automatic step();
        @(negedge clk_cog);
        if (vack === 1'b1) begin
            vack_cnt++;
            svid = 1'b0;
        end
    endtask

    task automatic do_tick();
        pll = 1'b1;
        repeat (3) step();
        pll = 1'b0;
        repeat (3) step();
    endtask

    task automatic run_ticks(input int n, input string name);
        logic [31:0] e;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(model(kidx));
            kidx++;
            do_tick();
            e = exp_q.pop_front();
            checks++;
            if (pin_out !== e) begin
                errors++;
                $display("FAIL %s tick %0d: pin_out=%h expected %h", name, kidx - 1, pin_out, e);
            end
        end
    endtask

    task automatic apply_reset();
        nres    = 1'b0;
        svid    = 1'b0;
        setvcfg = 1'b0;
        setvscl = 1'b0;
        ena     = 1'b1;
        for (int i = 0; i < 6; i++) begin
            pll = ~pll;
            step();
        end
        pll = 1'b0;
        step();
        nres = 1'b1;
        step();
    endtask

    task automatic start_video(input logic [31:0] vc, input logic [31:0] vs,
                               input logic [31:0] csc, input logic [31:0] csp);
        int t;
        m_sc   = csc;
        m_sp   = csp;
        m_mode = vc[28];
        m_g    = vc[25:24];
        m_mask = vc[7:0];
        m_p    = (vs[19:12] == 8'd0) ? 256 : vs[19:12];
        m_f    = (vs[11:0] == 12'd0) ? 4096 : vs[11:0];
        data = vs; setvscl = 1'b1; step(); setvscl = 1'b0;
        data = vc; setvcfg = 1'b1; step(); setvcfg = 1'b0;
        vack_cnt = 0;
        kidx     = 0;
        sc   = csc;
        sp   = csp;
        svid = 1'b1;
        t = 0;
        while (busy !== 1'b1 && t < 10) begin
            step();
            t++;
        end
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL start_busy: busy=%b expected 1", busy);
        end
    endtask

    task automatic test_reset();
        nres = 1'b0;
        ena  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            pll = ~pll;
            step();
        end
        checks += 3;
        if (pin_out !== 32'd0) begin errors++; $display("FAIL reset_pin: pin_out=%h expected 0", pin_out); end
        if (vack !== 1'b0) begin errors++; $display("FAIL reset_vack: vack=%b expected 0", vack); end
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: busy=%b expected 0", busy); end
        pll = 1'b0;
        step();
        nres = 1'b1;
        step();
        m_mask = 8'd0;
        kidx   = 0;
        run_ticks(3, "idle");
    endtask

    task automatic test_handshake_off();
        vack_cnt = 0;
        sc   = 32'h44332211;
        sp   = 32'd0;
        svid = 1'b1;
        step();
        checks += 2;
        if (busy !== 1'b1) begin errors++; $display("FAIL off_busy: busy=%b expected 1", busy); end
        if (vack !== 1'b0) begin errors++; $display("FAIL off_early_vack: vack=%b expected 0", vack); end
        step();
        checks++;
        if (vack !== 1'b1) begin errors++; $display("FAIL off_vack: vack=%b expected 1", vack); end
        repeat (6) step();
        checks += 2;
        if (vack_cnt !== 1) begin errors++; $display("FAIL off_vack_count: count=%0d expected 1", vack_cnt); end
        if (busy !== 1'b0) begin errors++; $display("FAIL off_busy_clear: busy=%b expected 0", busy); end
    endtask

    task automatic test_1bpp_and_starvation();
        apply_reset();
        start_video(32'h210000FF, 32'h00002008, 32'h0000AA55, 32'h0000000A);
        run_ticks(8, "1bpp");
        checks += 2;
        if (vack_cnt !== 1) begin errors++; $display("FAIL 1bpp_vack: count=%0d expected 1", vack_cnt); end
        if (busy !== 1'b0) begin errors++; $display("FAIL 1bpp_busy: busy=%b expected 0", busy); end
        run_ticks(8, "replay");
        checks += 2;
        if (vack_cnt !== 1) begin errors++; $display("FAIL replay_vack: count=%0d expected 1", vack_cnt); end
        if (busy !== 1'b0) begin errors++; $display("FAIL replay_busy: busy=%b expected 0", busy); end
    endtask

    task automatic test_2bpp_mask();
        apply_reset();
        start_video(32'h3300000F, 32'h00001004, 32'h44332211, 32'h000000E4);
        run_ticks(8, "2bpp");
        checks++;
        if (vack_cnt !== 1) begin errors++; $display("FAIL 2bpp_vack: count=%0d expected 1", vack_cnt); end
    endtask

    task automatic test_long_counts();
        apply_reset();
        start_video(32'h200000FF, 32'h00000000, 32'h0000AA55, 32'h00008002);
        run_ticks(4096 + 257, "long");
        checks++;
        if (vack_cnt !== 1) begin errors++; $display("FAIL long_vack: count=%0d expected 1", vack_cnt); end
    endtask

    task automatic test_ena_drop();
        apply_reset();
        start_video(32'h210000FF, 32'h00001008, 32'h0000AA55, 32'h0000000A);
        run_ticks(3, "pre_ena");
        ena = 1'b0;
        step();
        checks++;
        if (pin_out !== 32'd0) begin errors++; $display("FAIL ena_drop: pin_out=%h expected 0", pin_out); end
        step();
        ena = 1'b1;
        m_mask = 8'd0;
        run_ticks(2, "after_ena");
    endtask

    task automatic test_pll_high();
        logic [31:0] e;
        apply_reset();
        start_video(32'h210000FF, 32'h00001008, 32'h0000AA55, 32'hAAAAAAAA);
        run_ticks(2, "pre_hold");
        exp_q.push_back(model(kidx));
        exp_q.push_back(model(kidx));
        kidx++;
        pll = 1'b1;
        repeat (6) step();
        e = exp_q.pop_front();
        checks++;
        if (pin_out !== e) begin errors++; $display("FAIL pll_rise: pin_out=%h expected %h", pin_out, e); end
        repeat (41) step();
        e = exp_q.pop_front();
        checks++;
        if (pin_out !== e) begin errors++; $display("FAIL pll_held: pin_out=%h expected %h", pin_out, e); end
        pll = 1'b0;
        repeat (3) step();
        run_ticks(3, "post_hold");
    endtask

    task automatic test_reset_mid_frame();
        apply_reset();
        start_video(32'h210000FF, 32'h00002008, 32'h0000AA55, 32'h0000000A);
        run_ticks(2, "pre_reset");
        sc   = 32'h11223344;
        svid = 1'b1;
        step();
        step();
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy: busy=%b expected 1", busy); end
        nres = 1'b0;
        svid = 1'b0;
        step();
        checks += 3;
        if (busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy: busy=%b expected 0", busy); end
        if (vack !== 1'b0) begin errors++; $display("FAIL mid_rst_vack: vack=%b expected 0", vack); end
        if (pin_out !== 32'd0) begin errors++; $display("FAIL mid_rst_pin: pin_out=%h expected 0", pin_out); end
        nres = 1'b1;
        repeat (4) step();
        checks++;
        if (vack_cnt !== 1) begin errors++; $display("FAIL mid_rst_vcnt: count=%0d expected 1", vack_cnt); end
    endtask

    initial begin
        test_reset();
        test_handshake_off();
        test_1bpp_and_starvation();
        test_2bpp_mask();
        test_ena_drop();
        test_pll_high();
        test_reset_mid_frame();
        test_long_counts();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
